// File: rtl/pe_pkg.sv
// Shared definitions for the multiply-accumulate processing element family:
// default widths and the saturating/wrapping add used by the accumulator.
package pe_pkg;

    localparam int unsigned PE_DATA_W = 8;
    localparam int unsigned PE_ACC_W  = 20;

    // Widest accumulator the shared adder supports (ACC_W must stay below this).
    localparam int unsigned PE_MAX_W  = 64;

    localparam logic [PE_ACC_W-1:0] ACC_MAX = {PE_ACC_W{1'b1}};

    // Adds two values already confined to acc_w bits. Returns {ov, value},
    // where value is the acc_w-bit result (saturated or wrapped) zero-extended
    // to PE_MAX_W bits.
    function automatic logic [PE_MAX_W:0] sat_add(
        input logic [PE_MAX_W-1:0] acc,
        input logic [PE_MAX_W-1:0] p,
        input int unsigned         acc_w,
        input logic                sat_en
    );
        logic [PE_MAX_W:0]   sum;
        logic [PE_MAX_W-1:0] mask;
        logic [PE_MAX_W-1:0] value;
        logic                ov;
        sum = {1'b0, acc} + {1'b0, p};
        if (acc_w >= PE_MAX_W) begin
            mask = {PE_MAX_W{1'b1}};
        end else begin
            mask = (64'd1 << acc_w) - 64'd1;
        end
        ov = sum[PE_MAX_W] | (sum[PE_MAX_W-1:0] > mask);
        if (!ov) begin
            value = sum[PE_MAX_W-1:0];
        end else if (sat_en) begin
            value = mask;
        end else begin
            value = sum[PE_MAX_W-1:0] & mask;
        end
        return {ov, value};
    endfunction

endpackage

// File: rtl/pe_sat_accum.sv
// Accumulate stage: folds registered products into the group sum, tracks
// overflow across the group and publishes the result on the group's last pair.
// ACC_W must lie between 2*DATA_W and 63.
module pe_sat_accum
    import pe_pkg::*;
#(
    parameter int unsigned ACC_W  = PE_ACC_W,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_valid,
    input  logic             p_last,
    input  logic [ACC_W-1:0] p_data,
    output logic [ACC_W-1:0] res,
    output logic             res_valid,
    output logic             res_ovf
);

    logic [ACC_W-1:0]  acc_r;
    logic              ovf_r;
    logic [PE_MAX_W:0] add_s;
    logic [ACC_W-1:0]  nxt_s;
    logic              ov_s;
    logic              ovf_n_s;
    logic              unused_hi_s;

    // Next accumulator value and sticky overflow for the current product.
    always_comb begin
        add_s   = sat_add(PE_MAX_W'(acc_r), PE_MAX_W'(p_data), ACC_W, SAT_EN);
        nxt_s   = add_s[ACC_W-1:0];
        ov_s    = add_s[PE_MAX_W];
        ovf_n_s = ovf_r | ov_s;
    end

    // Upper adder bits are always zero for in-range operands.
    assign unused_hi_s = ^add_s[PE_MAX_W-1:ACC_W];

    // Accumulator update; the last pair publishes the result and restarts at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r     <= {ACC_W{1'b0}};
            ovf_r     <= 1'b0;
            res       <= {ACC_W{1'b0}};
            res_valid <= 1'b0;
            res_ovf   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (p_valid) begin
                if (p_last) begin
                    res       <= nxt_s;
                    res_ovf   <= ovf_n_s;
                    res_valid <= 1'b1;
                    acc_r     <= {ACC_W{1'b0}};
                    ovf_r     <= 1'b0;
                end else begin
                    acc_r     <= nxt_s;
                    ovf_r     <= ovf_n_s;
                end
            end
        end
    end

endmodule

// File: rtl/pe_mac_param.sv
// Systolic-array multiply-accumulate processing element: forwards operands
// east/south with one cycle of latency, registers the product, and hands it to
// the accumulate stage which emits one result per valid/last-delimited group.
module pe_mac_param
    import pe_pkg::*;
#(
    parameter int unsigned DATA_W = PE_DATA_W,
    parameter int unsigned ACC_W  = PE_ACC_W,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic              fwd_valid,
    output logic              fwd_last,
    output logic [ACC_W-1:0]  res,
    output logic              res_valid,
    output logic              res_ovf
);

    logic [2*DATA_W-1:0] prod_s;
    logic [ACC_W-1:0]    p1_r;
    logic                v1_r;
    logic                l1_r;

    // Full-width unsigned product of the incoming operand pair.
    always_comb begin
        prod_s = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);
    end

    // Forward path: operands advance only with valid data, flags every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out     <= {DATA_W{1'b0}};
            b_out     <= {DATA_W{1'b0}};
            fwd_valid <= 1'b0;
            fwd_last  <= 1'b0;
        end else begin
            if (in_valid) begin
                a_out <= a_in;
                b_out <= b_in;
            end
            fwd_valid <= in_valid;
            fwd_last  <= in_valid & in_last;
        end
    end

    // Stage 1: register the product with its valid/last qualifiers.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_r <= {ACC_W{1'b0}};
            v1_r <= 1'b0;
            l1_r <= 1'b0;
        end else if (in_valid) begin
            p1_r <= ACC_W'(prod_s);
            v1_r <= 1'b1;
            l1_r <= in_last;
        end else begin
            v1_r <= 1'b0;
        end
    end

    pe_sat_accum #(
        .ACC_W  (ACC_W),
        .SAT_EN (SAT_EN)
    ) u_accum (
        .clk       (clk),
        .rst       (rst),
        .p_valid   (v1_r),
        .p_last    (l1_r),
        .p_data    (p1_r),
        .res       (res),
        .res_valid (res_valid),
        .res_ovf   (res_ovf)
    );

endmodule

// File: tb/tb_pe_mac_param.sv
// Self-checking bench: three PE configurations share one stimulus stream and
// are compared each cycle against a group-level arithmetic reference model.
module tb_pe_mac_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_last;
    logic [7:0] a_in;
    logic [7:0] b_in;

    logic [7:0]  a0, b0, a1, b1, a2, b2;
    logic        fv0, fl0, rv0, ro0, fv1, fl1, rv1, ro1, fv2, fl2, rv2, ro2;
    logic [19:0] r0;
    logic [15:0] r1, r2;

    int checks   = 0;
    int failures = 0;

    // Reference state per instance: running unbounded group total, pending result.
    longint total;
    bit     pend_v;
    longint pend_total;
    longint last_res [3];
    bit     last_ovf [3];
    longint exp_a, exp_b;
    int     wid [3] = '{20, 16, 16};
    bit     sat [3] = '{1'b1, 1'b1, 1'b0};

    always #5 clk = ~clk;

    pe_mac_param #(.DATA_W(8), .ACC_W(20), .SAT_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .a_in(a_in), .b_in(b_in), .a_out(a0), .b_out(b0),
        .fwd_valid(fv0), .fwd_last(fl0), .res(r0), .res_valid(rv0), .res_ovf(ro0));

    pe_mac_param #(.DATA_W(8), .ACC_W(16), .SAT_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .a_in(a_in), .b_in(b_in), .a_out(a1), .b_out(b1),
        .fwd_valid(fv1), .fwd_last(fl1), .res(r1), .res_valid(rv1), .res_ovf(ro1));

    pe_mac_param #(.DATA_W(8), .ACC_W(16), .SAT_EN(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .a_in(a_in), .b_in(b_in), .a_out(a2), .b_out(b2),
        .fwd_valid(fv2), .fwd_last(fl2), .res(r2), .res_valid(rv2), .res_ovf(ro2));

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_res(input longint t, input int w, input bit s);
        longint lim;
        lim = (longint'(1) << w);
        if (t < lim) return t;
        if (s) return lim - 1;
        return t % lim;
    endfunction

    task automatic check_dut(input int i, input longint ao, input longint bo,
                             input longint fv, input longint fl, input longint r,
                             input longint rv, input longint ro, input longint erv,
                             input longint efv, input longint efl);
        chk($sformatf("d%0d_a_out", i), ao, exp_a);
        chk($sformatf("d%0d_b_out", i), bo, exp_b);
        chk($sformatf("d%0d_fwd_valid", i), fv, efv);
        chk($sformatf("d%0d_fwd_last", i), fl, efl);
        chk($sformatf("d%0d_res_valid", i), rv, erv);
        chk($sformatf("d%0d_res", i), r, last_res[i]);
        chk($sformatf("d%0d_res_ovf", i), ro, longint'(last_ovf[i]));
    endtask

    // Apply one cycle of inputs, advance the model, and check all instances.
    task automatic step(input bit r, input bit v, input bit l, input int a, input int b);
        bit erv, efv, efl;
        rst = r; in_valid = v; in_last = l;
        a_in = 8'(a); b_in = 8'(b);
        @(posedge clk);
        #1;
        if (r) begin
            total = 0; pend_v = 1'b0; exp_a = 0; exp_b = 0;
            erv = 1'b0; efv = 1'b0; efl = 1'b0;
            for (int i = 0; i < 3; i++) begin
                last_res[i] = 0; last_ovf[i] = 1'b0;
            end
        end else begin
            erv = pend_v;
            if (pend_v) begin
                for (int i = 0; i < 3; i++) begin
                    last_res[i] = model_res(pend_total, wid[i], sat[i]);
                    last_ovf[i] = pend_total >= (longint'(1) << wid[i]);
                end
            end
            efv = v;
            efl = v & l;
            pend_v = 1'b0;
            if (v) begin
                exp_a = a; exp_b = b;
                total += longint'(a) * longint'(b);
                if (l) begin
                    pend_v = 1'b1; pend_total = total; total = 0;
                end
            end
        end
        check_dut(0, a0, b0, fv0, fl0, r0, rv0, ro0, erv, efv, efl);
        check_dut(1, a1, b1, fv1, fl1, r1, rv1, ro1, erv, efv, efl);
        check_dut(2, a2, b2, fv2, fl2, r2, rv2, ro2, erv, efv, efl);
    endtask

    initial begin
        total = 0; pend_v = 1'b0; pend_total = 0; exp_a = 0; exp_b = 0;
        for (int i = 0; i < 3; i++) begin
            last_res[i] = 0; last_ovf[i] = 1'b0;
        end
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b1, 1'b1, 7, 7);

        // Basic group.
        step(1'b0, 1'b1, 1'b0, 3, 4);
        step(1'b0, 1'b1, 1'b1, 5, 6);
        chk("basic_early_valid", rv0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("basic_res", r0, 42);
        chk("basic_res_valid", rv0, 1);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("basic_pulse_end", rv0, 0);

        // Bubble inside a group, then back-to-back single-element group.
        step(1'b0, 1'b1, 1'b0, 2, 2);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 1, 7);
        step(1'b0, 1'b1, 1'b1, 10, 10);
        chk("b2b_first", r0, 11);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("b2b_second", r0, 100);

        // Overflow: saturating and wrapping 16-bit instances.
        step(1'b0, 1'b1, 1'b0, 255, 255);
        step(1'b0, 1'b1, 1'b1, 255, 255);
        step(1'b0, 1'b1, 1'b1, 1, 1);
        chk("sat_res", r1, 65535);
        chk("sat_ovf", ro1, 1);
        chk("wrap_res", r2, 64514);
        chk("wrap_ovf", ro2, 1);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("sat_next_res", r1, 1);
        chk("sat_next_ovf", ro1, 0);

        // Reset mid-group discards the partial sum.
        step(1'b0, 1'b1, 1'b0, 9, 9);
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b1, 1'b1, 2, 3);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("reset_group_res", r0, 6);

        // Forwarding hold and ignored unqualified last.
        step(1'b0, 1'b0, 1'b0, 8'hAA, 8'h55);
        chk("hold_a_out", a0, 2);
        step(1'b0, 1'b0, 1'b1, 8'hAA, 8'h55);
        chk("hold_fwd_last", fl0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);
        chk("hold_no_result", rv0, 0);

        // Randomized traffic with occasional resets and large operands.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255)));
        end
        step(1'b0, 1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_mac_param.md
Name: pe_mac_param

Overview:
Parametrised systolic-array processing element, the next generation of the 8-bit multiply-accumulate PE. It multiplies operand pairs, accumulates them into a wide accumulator and forwards the operands to its east and south neighbours one cycle later. A valid/last handshake delimits each dot-product group, replacing the old block-strobe scheme. Results are emitted with an overflow indication, and the accumulator can be configured to saturate or wrap.

Parameters:
DATA_W, 8, operand width; operands are unsigned.
ACC_W, 20, accumulator/result width; must be ≥ 2*DATA_W.
SAT_EN, 1, 1 = saturate at 2^ACC_W-1 on overflow; 0 = wrap modulo 2^ACC_W.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  a_in/b_in/in_last are valid this cycle.
in_last  in  1  last operand pair of the current group; qualified by in_valid.
a_in  in  DATA_W  west operand.
b_in  in  DATA_W  north operand.
a_out  out  DATA_W  registered a_in, forwarded east.
b_out  out  DATA_W  registered b_in, forwarded south.
fwd_valid  out  1  registered in_valid.
fwd_last  out  1  registered in_valid&in_last.
res  out  ACC_W  completed group sum.
res_valid  out  1  one-cycle pulse; res is valid.
res_ovf  out  1  group overflowed; qualified by res_valid.

Behaviour:
- Reset (rst=1 at an edge): every output, including a_out, b_out, fwd_valid, fwd_last, res, res_valid and res_ovf, goes to 0. The accumulator, the overflow flag and the pipeline registers also clear. Any partial sum is discarded, and no res_valid is produced for an interrupted group. Reset has priority over all other inputs.
- Forward path, latency 1: a_out/b_out load a_in/b_in only when in_valid=1 and otherwise hold. fwd_valid and fwd_last are registered every cycle.
- Stage 1, product register: when in_valid=1, p1 <= a_in*b_in (full 2*DATA_W, zero-extended to ACC_W), v1 <= 1 and l1 <= in_last. Otherwise v1 <= 0.
- Stage 2, accumulate, on edges where v1=1:
  - sum = acc + p1, computed at ACC_W+1 bits; ov = sum[ACC_W].
  - nxt = sum[ACC_W-1:0] if ov=0. If ov=1, nxt = all-ones when SAT_EN=1, or the truncated sum when SAT_EN=0.
  - ovf_n = ovf | ov.
  - If l1=0: acc <= nxt and ovf <= ovf_n.
  - If l1=1: res <= nxt, res_ovf <= ovf_n, res_valid <= 1, acc <= 0 and ovf <= 0, all at the same edge.
- res_valid is 1 for exactly one cycle. res and res_ovf hold their values until the next result.
- Latency: in_valid&in_last sampled at edge E produces res_valid high in the cycle after edge E+1, i.e. 2 cycles.
- Bubbles (in_valid=0) inside a group are legal. The accumulator holds and the result is unaffected.
- Back-to-back groups: a pair with in_last=1 may be followed immediately by a pair from the next group. The new group starts from acc=0 with no bubble.
- A single-element group (in_valid=in_last=1 for one pair) yields res = a*b.
- in_last with in_valid=0 is ignored.
- Once saturated, the accumulator stays at all-ones for the rest of the group in SAT_EN=1 mode. Adding a nonnegative product can only re-overflow or hold.

Decomposition:
- Shared package pe_pkg:
  - default widths (PE_DATA_W=8, PE_ACC_W=20);
  - a function sat_add(acc, p, sat_en) returning {ov, value};
  - a localparam ACC_MAX = all-ones of ACC_W.
- One sub-module is natural: pe_sat_accum, containing stage 2 (accumulator, overflow flag, result registers).
- The top module holds the forward registers and the stage-1 product register.

Test Plan:
- Basic group (DATA_W=8, ACC_W=20): pairs (3,4), (5,6), the latter with in_last, on consecutive cycles → res=42, res_ovf=0, res_valid a single pulse 2 cycles after the last pair; a_out/b_out each trail their input by 1 cycle.
- Bubbles and back-to-back groups: (2,2), idle, (1,7,last), then immediately (10,10,last) → res=11, then res=100 on the next cycle, with no leakage from the first group into the second.
- Saturation (ACC_W=16, SAT_EN=1): (255,255), (255,255,last) → res=65535, res_ovf=1. The next group (1,1,last) → res=1, res_ovf=0.
- Wrap (ACC_W=16, SAT_EN=0): same stimulus as the saturation test → res=64514 (130050 mod 65536), res_ovf=1.
- Reset mid-group: (9,9), then rst=1 for 1 cycle, then (2,3,last) → all outputs 0 during reset, no result for the aborted group, then res=6.
- Forwarding hold: in_valid=0 while a_in=0xAA → a_out keeps its previous value and fwd_valid=0. With in_valid=0 and in_last=1 → fwd_last=0 and no res_valid.
